// File: rtl/nibble_sort_ctrl_if.sv
// rtl/nibble_sort_ctrl_if.sv - request, result and comparator bus bundle for nibble_sort_ctrl
//
// Signals:
//   start    request a sort (sampled only while the sequencer is idle)
//   data_in  four 4-bit elements, element k = data_in[4k+3:4k]
//   cmp_num  comparator operand bus {A, B}
//   cmp_sel  comparator function select
//   cmp_res  comparator result (bit 0 only)
//   busy     sort in progress
//   done     one-cycle pulse when sorted is valid
//   sorted   sorted elements, same packing as data_in
//   swaps    swap count of the last completed sort
// Modports: master = sort sequencer, slave = surrounding logic plus comparator.
interface nibble_sort_ctrl_if;
    logic        start;
    logic [15:0] data_in;
    logic [7:0]  cmp_num;
    logic [1:0]  cmp_sel;
    logic [7:0]  cmp_res;
    logic        busy;
    logic        done;
    logic [15:0] sorted;
    logic [2:0]  swaps;

    modport master (
        input  start, data_in, cmp_res,
        output cmp_num, cmp_sel, busy, done, sorted, swaps
    );

    modport slave (
        output start, data_in, cmp_res,
        input  cmp_num, cmp_sel, busy, done, sorted, swaps
    );
endinterface

// File: rtl/nibble_sort_ctrl.sv
// rtl/nibble_sort_ctrl.sv - four-element nibble bubble sort sharing one external comparator
//
// Parameters:
//   DESCEND  0 = ascending (element 0 smallest), 1 = descending (element 0 largest)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nibble_sort_ctrl_if.master (start/data_in in, comparator bus, busy/done/sorted/swaps out)
// Each of the six compare/swap operations takes two cycles: ISSUE drives the
// operand pair and captures the comparator answer, EVAL applies the swap.
module nibble_sort_ctrl #(
    parameter bit DESCEND = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_sort_ctrl_if.master    bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, EVAL, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [3:0]  elem_q   [4];
    logic [3:0]  elem_swp [4];
    logic        gt_q;
    logic [15:0] sorted_q;
    logic [2:0]  swaps_q;
    logic [1:0]  idx;
    logic [1:0]  idx_nx;
    logic        unused_res;

    // Upper result bits carry nothing for the two functions in use.
    assign unused_res = ^bus.cmp_res[7:1];

    // A > B swaps toward ascending, A < B toward descending; equal never swaps.
    assign bus.cmp_sel = DESCEND ? 2'b10 : 2'b01;
    assign bus.sorted  = sorted_q;
    assign bus.swaps   = swaps_q;

    // Lower element of the pair for each op: three passes of 3, 2, 1 compares.
    always_comb begin
        idx = 2'd0;
        case (op_q)
            3'd1:    idx = 2'd1;
            3'd2:    idx = 2'd2;
            3'd4:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

    assign idx_nx = idx + 2'd1;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            elem_swp[k] = elem_q[k];
        end
        if (gt_q) begin
            elem_swp[idx]    = elem_q[idx_nx];
            elem_swp[idx_nx] = elem_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.cmp_num = 8'h00;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.busy    = 1'b1;
                bus.cmp_num = {elem_q[idx], elem_q[idx_nx]};
                state_d     = EVAL;
            end
            EVAL: begin
                bus.busy = 1'b1;
                state_d  = (op_q == 3'd5) ? DONE : ISSUE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'd0;
            gt_q     <= 1'b0;
            sorted_q <= 16'h0000;
            swaps_q  <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                elem_q[k] <= 4'h0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= 3'd0;
                        swaps_q <= 3'd0;
                        for (int k = 0; k < 4; k++) begin
                            elem_q[k] <= bus.data_in[4*k +: 4];
                        end
                    end
                end
                ISSUE: begin
                    gt_q <= bus.cmp_res[0];
                end
                EVAL: begin
                    for (int k = 0; k < 4; k++) begin
                        elem_q[k] <= elem_swp[k];
                    end
                    if (gt_q) begin
                        swaps_q <= swaps_q + 3'd1;
                    end
                    if (op_q == 3'd5) begin
                        sorted_q <= {elem_swp[3], elem_swp[2], elem_swp[1], elem_swp[0]};
                    end else begin
                        op_q <= op_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// tb/tb_nibble_sort_ctrl.sv - directed self-checking bench for nibble_sort_ctrl
module tb_nibble_sort_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_sort_ctrl_if b0 ();
    nibble_sort_ctrl_if b1 ();

    nibble_sort_ctrl #(.DESCEND(1'b0)) dut_asc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    nibble_sort_ctrl #(.DESCEND(1'b1)) dut_desc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    function automatic logic cmp_model(input logic [7:0] num, input logic [1:0] sel);
        case (sel)
            2'b01:   return num[7:4] > num[3:0];
            2'b10:   return num[7:4] < num[3:0];
            default: return 1'b0;
        endcase
    endfunction

    // Junk in the upper result bits must be ignored by the sequencer.
    assign b0.cmp_res = {7'h55, cmp_model(b0.cmp_num, b0.cmp_sel)};
    assign b1.cmp_res = {7'h2A, cmp_model(b1.cmp_num, b1.cmp_sel)};

    int errors = 0;
    int checks = 0;

    logic        which;
    logic [7:0]  o_num;
    logic [1:0]  o_sel;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_sorted;
    logic [2:0]  o_swaps;

    always_comb begin
        if (which) begin
            o_num = b1.cmp_num; o_sel = b1.cmp_sel; o_busy = b1.busy;
            o_done = b1.done; o_sorted = b1.sorted; o_swaps = b1.swaps;
        end else begin
            o_num = b0.cmp_num; o_sel = b0.cmp_sel; o_busy = b0.busy;
            o_done = b0.done; o_sorted = b0.sorted; o_swaps = b0.swaps;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic s, input logic [15:0] d);
        if (w) begin
            b1.start = s; b1.data_in = d;
        end else begin
            b0.start = s; b0.data_in = d;
        end
    endtask

    // Starts from a negedge with the DUT idle; ends at the negedge of cycle 14 (idle again).
    task automatic run_sort(input string tag, input logic w, input logic [15:0] d,
                            input logic [15:0] exp_sorted, input logic [2:0] exp_swaps,
                            input bit chk_num);
        logic [7:0] exp_num [6] = '{8'hF3, 8'hFA, 8'hF1, 8'h3A, 8'hA1, 8'h31};
        int busy_n  = 0;
        int done_n  = 0;
        int done_c  = 0;
        int sel_bad = 0;
        which = w;
        drive(w, 1'b1, d);
        @(posedge clk);
        #1 drive(w, 1'b0, 16'h0000);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (o_busy) busy_n++;
            if (o_done) begin
                done_n++;
                if (done_c == 0) done_c = c;
            end
            if (o_sel !== (w ? 2'b10 : 2'b01)) sel_bad++;
            if (chk_num) begin
                if ((c % 2 == 1) && (c <= 11))
                    check({tag, " cmp_num issue"}, o_num, exp_num[(c-1)/2]);
                else
                    check({tag, " cmp_num idle"}, o_num, 8'h00);
            end
        end
        check({tag, " busy cycles"}, busy_n, 12);
        check({tag, " done cycle"}, done_c, 13);
        check({tag, " done pulses"}, done_n, 1);
        check({tag, " cmp_sel"}, sel_bad, 0);
        check({tag, " sorted"}, o_sorted, exp_sorted);
        check({tag, " swaps"}, o_swaps, exp_swaps);
        @(negedge clk);
        check({tag, " idle after done"}, {o_busy, o_done}, 2'b00);
    endtask

    initial begin
        int done_n;
        int first_c;
        int second_c;
        rst_n = 1'b0;
        which = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        check("reset busy", {b0.busy, b1.busy}, 2'b00);
        check("reset done", {b0.done, b1.done}, 2'b00);
        check("reset sorted", {b0.sorted, b1.sorted}, 32'h0);
        check("reset swaps", {b0.swaps, b1.swaps}, 6'h0);
        check("reset cmp_num", {b0.cmp_num, b1.cmp_num}, 16'h0);
        check("cmp_sel asc", b0.cmp_sel, 2'b01);
        check("cmp_sel desc", b1.cmp_sel, 2'b10);
        rst_n = 1'b1;
        @(negedge clk);

        run_sort("asc 1A3F", 1'b0, 16'h1A3F, 16'hFA31, 3'd5, 1'b1);
        run_sort("asc 13AF", 1'b0, 16'h13AF, 16'hFA31, 3'd6, 1'b0);
        run_sort("asc FA31", 1'b0, 16'hFA31, 16'hFA31, 3'd0, 1'b0);
        run_sort("asc 7777", 1'b0, 16'h7777, 16'h7777, 3'd0, 1'b0);
        run_sort("desc FA31", 1'b1, 16'hFA31, 16'h13AF, 3'd6, 1'b0);

        // start held high; data_in changes mid-sort and feeds only the second sort
        which = 1'b0;
        done_n = 0; first_c = 0; second_c = 0;
        drive(1'b0, 1'b1, 16'h1A3F);
        @(posedge clk);
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            if (o_done) begin
                done_n++;
                if (first_c == 0) first_c = c;
                else second_c = c;
            end
            if (c == 3) b0.data_in = 16'h7777;
            if (c == 13) begin
                check("held first sorted", o_sorted, 16'hFA31);
                check("held first swaps", o_swaps, 3'd5);
            end
            if (c == 14) check("held idle gap", o_busy, 1'b0);
            if (c == 20) check("held second busy", o_busy, 1'b1);
            if (c == 27) b0.start = 1'b0;
        end
        check("held done pulses", done_n, 2);
        check("held first done", first_c, 13);
        check("held second done", second_c, 27);
        check("held second sorted", o_sorted, 16'h7777);
        check("held second swaps", o_swaps, 3'd0);
        check("held ends idle", o_busy, 1'b0);

        // asynchronous reset in cycle 6 of a sort
        drive(1'b0, 1'b1, 16'h1A3F);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 16'h0000);
        repeat (6) @(negedge clk);
        check("pre-reset busy", b0.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", b0.busy, 1'b0);
        check("mid reset done", b0.done, 1'b0);
        check("mid reset sorted", b0.sorted, 16'h0000);
        check("mid reset swaps", b0.swaps, 3'd0);
        check("mid reset cmp_num", b0.cmp_num, 8'h00);
        check("mid reset desc sorted", b1.sorted, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sort("post-reset 1A3F", 1'b0, 16'h1A3F, 16'hFA31, 3'd5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_sort_ctrl.md
Name: nibble_sort_ctrl

Overview:
- Sequencer that sorts four 4-bit values by time-sharing one external nibble comparator.
- It issues bubble-sort compare/swap operations on the comparator's 8-bit operand bus and reads back its 1-bit result.
- It sits between the switch/key input logic and the seven-segment output path, beside the comparator.
- The comparator is combinational: A is operand[7:4], B is operand[3:0]. Select 01 returns A>B and select 10 returns A<B, both in result bit 0.

Parameters:
DESCEND, 0, sort order: 0 = ascending (element 0 smallest), 1 = descending (element 0 largest)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request a sort; sampled only in IDLE
data_in  input  16  four elements; element k = data_in[4k+3:4k]
cmp_num  output  8  comparator operand bus {A, B}
cmp_sel  output  2  comparator function select
cmp_res  input  8  comparator result; only bit 0 is used
busy  output  1  high while a sort is in progress
done  output  1  one-cycle pulse when sorted is valid
sorted  output  16  sorted elements, same packing as data_in
swaps  output  3  number of swaps performed in the last sort (0..6)

Behaviour:
- Reset (rst_n low, any time, including mid-sort): state = IDLE. busy = 0, done = 0, sorted = 0, swaps = 0, cmp_num = 0, element registers = 0. Release is synchronous to clk.
- cmp_sel is constant: 2'b01 when DESCEND = 0, 2'b10 when DESCEND = 1. It does not depend on state.
- States: IDLE, ISSUE, EVAL, DONE. There is a 3-bit op index, 0..5.
- IDLE: if start = 1 at a rising edge, load the element registers from data_in, clear swaps to 0, set op = 0, go to ISSUE. busy goes high from that edge.
- Pair schedule by op index 0..5: (0,1), (1,2), (2,3), (0,1), (1,2), (0,1).
- ISSUE (1 cycle): cmp_num = {elem[i], elem[i+1]} for the current pair. At the clock edge, register cmp_res[0] into gt_q, then go to EVAL.
- EVAL (1 cycle): cmp_num = 0.
  - If gt_q = 1, exchange elem[i] and elem[i+1] and increment swaps at this edge.
  - Equal values never swap, so the sort is stable.
  - If op < 5: op increments and the next state is ISSUE.
  - If op = 5: write sorted from the final element values (including this edge's swap) and go to DONE.
- DONE (1 cycle): done = 1, busy = 0, then go to IDLE.
- Fixed latency: if start is sampled at edge E0, busy is high for cycles 1..12 and done is high only in cycle 13. The next start can be accepted at the end of cycle 14 (IDLE).
- cmp_num = 0 in IDLE, EVAL and DONE; it is nonzero only in ISSUE.
- start while busy or in DONE: ignored. data_in changes during a sort: ignored, because data_in is captured only at acceptance.
- sorted and swaps hold their values until the next completed sort. They do not update on a new start until that sort's final EVAL edge; swaps clears at acceptance.
- cmp_res[7:1] is ignored.

Test Plan:
- DESCEND = 0, data_in = 16'h1A3F (elements F,3,A,1), start pulse -> done in cycle 13 after the start edge, sorted = 16'hFA31, swaps = 5, busy high for exactly 12 cycles.
- DESCEND = 0, data_in = 16'h13AF (elements F,A,3,1, fully reversed) -> sorted = 16'hFA31, swaps = 6; already-sorted data_in = 16'hFA31 -> sorted = 16'hFA31, swaps = 0; data_in = 16'h7777 -> swaps = 0.
- DESCEND = 1, data_in = 16'hFA31 -> sorted = 16'h13AF, swaps = 6, cmp_sel = 2'b10 throughout.
- Bench models the comparator combinationally. Check cmp_num on each ISSUE cycle for 16'h1A3F: 8'hF3, 8'hFA, 8'hF1, 8'h3A, 8'hA1, 8'h31, and check cmp_num = 0 on EVAL cycles.
- start held high continuously, with data_in changed mid-sort -> only the first data is sorted; a second sort begins after DONE->IDLE, with no overlap or lost done pulse.
- rst_n low in cycle 6 of a sort -> busy, done, sorted, swaps and cmp_num all read 0 immediately (asynchronously); after release, a fresh sort of 16'h1A3F gives 16'hFA31.
